// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: wait-state instruction fetch sequencer with a 2-entry prefetch buffer.
// Optional macro IFETCH_BOUND_CHECK_EN enables alignment/range checking of the fetch PC.
`default_nettype none

module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WAIT  = 4,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        busy,
  output logic        fault
);

  localparam int unsigned WCNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [WCNT_W-1:0] c_WCNT_LAST = WCNT_W'(MEM_WAIT - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_FULL  = 2'd2;
  localparam logic [1:0] c_FAULT = 2'd3;

  generate
    if (MEM_WAIT < 1 || MEM_WORDS == 0) begin : g_bad_cfg
      $error("instr_fetch_ctrl: MEM_WAIT and MEM_WORDS must be at least 1");
    end
  endgenerate

  logic [1:0]        r_state;
  logic [31:0]       r_pc;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_mem_req;
  logic              r_busy;
  logic              r_fault;
  logic              r_v0, r_v1;
  logic [31:0]       r_instr0, r_instr1, r_pc0, r_pc1;

  logic              w_pop, w_fire, w_push;
  logic [1:0]        w_occ_next;
  logic [1:0]        w_state_nxt;
  logic [31:0]       w_pc_nxt;
  logic [WCNT_W-1:0] w_wcnt_nxt;

  // Redirect overrides any push/pop happening in the same cycle.
  assign w_pop      = r_v0 && out_ready && !redirect_valid;
  assign w_fire     = (r_state == c_WAIT) && (r_wcnt == c_WCNT_LAST);
  assign w_push     = w_fire && !redirect_valid;
  assign w_occ_next = {1'b0, r_v0} + {1'b0, r_v1} + {1'b0, w_push} - {1'b0, w_pop};

`ifdef IFETCH_BOUND_CHECK_EN
  logic w_pc_illegal;
  assign w_pc_illegal = (w_pc_nxt[1:0] != 2'b00) ||
                        ({2'b00, w_pc_nxt[31:2]} >= 32'(MEM_WORDS));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_wcnt_nxt  = r_wcnt;
    if (redirect_valid) begin
      w_pc_nxt    = redirect_pc;
      w_wcnt_nxt  = '0;
      w_state_nxt = c_WAIT;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            w_state_nxt = c_WAIT;
            w_wcnt_nxt  = '0;
          end
        end
        c_WAIT: begin
          if (w_fire) begin
            w_pc_nxt    = r_pc + 32'd4;
            w_wcnt_nxt  = '0;
            w_state_nxt = (w_occ_next == 2'd2) ? c_FULL : c_WAIT;
          end else begin
            w_wcnt_nxt = r_wcnt + 1'b1;
          end
        end
        c_FULL: begin
          if (w_pop) begin
            w_state_nxt = c_WAIT;
            w_wcnt_nxt  = '0;
          end
        end
        default: ;
      endcase
    end
`ifdef IFETCH_BOUND_CHECK_EN
    // Every entry into (or continuation of) a fetch is vetted before mem_req rises.
    if (w_state_nxt == c_WAIT && w_pc_illegal) begin
      w_state_nxt = c_FAULT;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_pc      <= RESET_PC;
      r_wcnt    <= '0;
      r_mem_req <= 1'b0;
      r_busy    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_mem_req <= (w_state_nxt == c_WAIT);
      r_busy    <= (w_state_nxt != c_IDLE);
      r_fault   <= (w_state_nxt == c_FAULT);
    end
  end

  // Entry 0 is always the head; entry 1 only holds data while entry 0 does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0     <= 1'b0;
      r_v1     <= 1'b0;
      r_instr0 <= '0;
      r_instr1 <= '0;
      r_pc0    <= '0;
      r_pc1    <= '0;
    end else if (redirect_valid) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
    end else if (w_pop && w_push) begin
      if (r_v1) begin
        r_instr0 <= r_instr1;
        r_pc0    <= r_pc1;
        r_instr1 <= mem_rdata;
        r_pc1    <= r_pc;
      end else begin
        r_instr0 <= mem_rdata;
        r_pc0    <= r_pc;
      end
    end else if (w_pop) begin
      r_v0     <= r_v1;
      r_v1     <= 1'b0;
      r_instr0 <= r_instr1;
      r_pc0    <= r_pc1;
    end else if (w_push) begin
      if (!r_v0) begin
        r_v0     <= 1'b1;
        r_instr0 <= mem_rdata;
        r_pc0    <= r_pc;
      end else begin
        r_v1     <= 1'b1;
        r_instr1 <= mem_rdata;
        r_pc1    <= r_pc;
      end
    end
  end

  assign mem_addr  = r_pc;
  assign mem_req   = r_mem_req;
  assign busy      = r_busy;
  assign out_valid = r_v0;
  assign out_instr = r_instr0;
  assign out_pc    = r_pc0;

`ifdef IFETCH_BOUND_CHECK_EN
  assign fault = r_fault;
`else
  assign fault = 1'b0;
  logic w_unused_fault;
  assign w_unused_fault = r_fault;
`endif

endmodule

`default_nettype wire
